// File: rtl/pipelined_borrow_lookahead_subtractor.sv
// Two-stage pipelined 16-bit subtractor, D = A - B - Bin, with two-level
// borrow lookahead split across the stage register and a global-stall
// valid/ready handshake.
module pipelined_borrow_lookahead_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned BLK_W = 4;
  localparam int unsigned N_BLK = WIDTH / BLK_W;

  logic             advance_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] p_c;
  logic [N_BLK-1:0] gg_c;
  logic [N_BLK-1:0] pp_c;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [N_BLK-1:0] s1_gg;
  logic [N_BLK-1:0] s1_pp;
  logic             s1_bin;
  logic             s1_a15;
  logic             s1_b15;

  logic [N_BLK:0]   blk_b_c;
  logic [WIDTH-1:0] bit_b_c;
  logic [WIDTH-1:0] d_c;
  logic             unused_top_terms;

  // Global stall: every stage moves together when the output is free.
  assign advance_c = out_ready | ~out_valid;
  assign in_ready  = advance_c;

  // Bit generate/propagate and per-block group terms, flattened sum of products.
  always_comb begin
    logic term;
    term = 1'b0;
    g_c  = ~A & B;
    p_c  = ~(A ^ B);
    gg_c = '0;
    pp_c = '1;
    for (int k = 0; k < int'(N_BLK); k++) begin
      for (int j = 0; j < int'(BLK_W); j++) begin
        term = g_c[k*BLK_W + j];
        for (int m = j + 1; m < int'(BLK_W); m++) term &= p_c[k*BLK_W + m];
        gg_c[k] |= term;
        pp_c[k] &= p_c[k*BLK_W + j];
      end
    end
  end

  // Block borrows from group terms, then in-block bit borrows, both two-level.
  always_comb begin
    logic term;
    logic acc;
    term    = 1'b0;
    acc     = 1'b0;
    blk_b_c = '0;
    bit_b_c = '0;
    blk_b_c[0] = s1_bin;
    for (int k = 0; k < int'(N_BLK); k++) begin
      term = s1_bin;
      for (int m = 0; m <= k; m++) term &= s1_pp[m];
      acc = term;
      for (int j = 0; j <= k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m <= k; m++) term &= s1_pp[m];
        acc |= term;
      end
      blk_b_c[k+1] = acc;
    end
    for (int k = 0; k < int'(N_BLK); k++) begin
      for (int i = 0; i < int'(BLK_W); i++) begin
        term = blk_b_c[k];
        for (int m = 0; m < i; m++) term &= s1_p[k*BLK_W + m];
        acc = term;
        for (int j = 0; j < i; j++) begin
          term = s1_g[k*BLK_W + j];
          for (int m = j + 1; m < i; m++) term &= s1_p[k*BLK_W + m];
          acc |= term;
        end
        bit_b_c[k*BLK_W + i] = acc;
      end
    end
    d_c = s1_x ^ bit_b_c;
  end

  // Top-of-block bit terms are already folded into the registered group terms.
  always_comb begin
    unused_top_terms = 1'b0;
    for (int k = 0; k < int'(N_BLK); k++)
      unused_top_terms ^= s1_g[k*BLK_W + BLK_W - 1] ^ s1_p[k*BLK_W + BLK_W - 1];
  end

  // Stage 1: capture operand terms only when a token is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_gg    <= '0;
      s1_pp    <= '0;
      s1_bin   <= 1'b0;
      s1_a15   <= 1'b0;
      s1_b15   <= 1'b0;
    end else if (advance_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= A ^ B;
        s1_g   <= g_c;
        s1_p   <= p_c;
        s1_gg  <= gg_c;
        s1_pp  <= pp_c;
        s1_bin <= Bin;
        s1_a15 <= A[WIDTH-1];
        s1_b15 <= B[WIDTH-1];
      end
    end
  end

  // Stage 2: result and flags, loaded only from a valid stage-1 token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        D    <= d_c;
        Bout <= blk_b_c[N_BLK];
        zero <= ~|d_c;
        ovf  <= (s1_a15 != s1_b15) & (d_c[WIDTH-1] != s1_a15);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_borrow_lookahead_subtractor.sv
// Directed and random checks for the pipelined borrow-lookahead subtractor.
module tb_pipelined_borrow_lookahead_subtractor;

  localparam int N_RAND = 10000;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] D;
  logic        Bout;
  logic        zero;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  pipelined_borrow_lookahead_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
    .zero      (zero),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {D, Bout, zero, ovf} from wide unsigned and signed arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic bi);
    logic [16:0] diff;
    int          sd;
    diff = {1'b0, a} - {1'b0, b} - 17'(bi);
    sd   = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return {diff[15:0], diff[16], diff[15:0] == 16'h0000, (sd < -32768) || (sd > 32767)};
  endfunction

  // Push one operand set into an empty pipeline and collect its result.
  task automatic run_vec(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [18:0] res, output int lat);
    @(negedge clk);
    A = a; B = b; Bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    res = 'x;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        res = {D, Bout, zero, ovf};
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, D, Bout, zero, ovf, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_power_on: got %h want %h",
               {out_valid, D, Bout, zero, ovf, in_ready}, {1'b0, 16'h0000, 3'b000, 1'b1});
    end
    rst = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    A = 16'h0009; B = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, D} !== {2'b10, 16'hFFFE}) begin
      n_fail++;
      $display("FAIL reset_inflight: got %h want %h", {out_valid, in_ready, D}, {2'b10, 16'hFFFE});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, D, Bout, zero, ovf, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h",
               {out_valid, D, Bout, zero, ovf, in_ready}, {1'b0, 16'h0000, 3'b000, 1'b1});
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_stale: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_basic();
    logic [18:0] res;
    int          lat;
    run_vec(16'h1234, 16'h0234, 1'b0, res, lat);
    n_cmp++;
    if (res !== {16'h1000, 3'b000}) begin
      n_fail++;
      $display("FAIL basic_result: got %h want %h", res, {16'h1000, 3'b000});
    end
    n_cmp++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 1", lat);
    end
  endtask

  task automatic test_borrow_chain();
    logic [15:0] va [2] = '{16'h1000, 16'h0000};
    logic [15:0] vb [2] = '{16'h0001, 16'h0001};
    logic [18:0] ve [2] = '{{16'h0FFF, 3'b000}, {16'hFFFF, 3'b100}};
    logic [18:0] res;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_vec(va[i], vb[i], 1'b0, res, lat);
      n_cmp++;
      if (res !== ve[i] || lat !== 1) begin
        n_fail++;
        $display("FAIL chain_%0d: got %h lat %0d want %h lat 1", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_flags();
    logic [15:0] va [5] = '{16'h8000, 16'h5555, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [15:0] vb [5] = '{16'h0001, 16'h5554, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic        vi [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [18:0] ve [5] = '{{16'h7FFF, 3'b001}, {16'h0000, 3'b010}, {16'h8000, 3'b101},
                            {16'hFFFF, 3'b100}, {16'h0000, 3'b110}};
    logic [18:0] res;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_vec(va[i], vb[i], vi[i], res, lat);
      n_cmp++;
      if (res !== ve[i] || lat !== 1) begin
        n_fail++;
        $display("FAIL flags_%0d: got %h lat %0d want %h lat 1", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [4] = '{16'h0003, 16'h0100, 16'h0010, 16'h4000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0020, 16'h0FFF};
    logic        vi [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [18:0] ve [4] = '{{16'h0002, 3'b000}, {16'h00FF, 3'b000}, {16'hFFF0, 3'b100},
                            {16'h3000, 3'b000}};
    logic [18:0] held;
    logic        have_held;
    int          idx;
    int          rcv;
    int          cyc;
    idx = 0; rcv = 0; cyc = 0; have_held = 1'b0; held = '0;
    while (rcv < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      in_valid  = (idx < 4);
      if (idx < 4) begin A = va[idx]; B = vb[idx]; Bin = vi[idx]; end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready: got %b want 0 (cycle %0d)", in_ready, cyc);
        end
        if (have_held) begin
          n_cmp++;
          if ({D, Bout, zero, ovf} !== held) begin
            n_fail++;
            $display("FAIL bp_hold: got %h want %h (cycle %0d)", {D, Bout, zero, ovf}, held, cyc);
          end
        end
        held = {D, Bout, zero, ovf};
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({D, Bout, zero, ovf} !== ve[rcv]) begin
          n_fail++;
          $display("FAIL bp_result_%0d: got %h want %h", rcv, {D, Bout, zero, ovf}, ve[rcv]);
        end
        rcv++;
      end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (rcv !== 4 || idx !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d out %0d in want 4 out 4 in", rcv, idx);
    end
  endtask

  task automatic test_random();
    logic [18:0] q [$];
    logic [18:0] exp_v;
    logic        hold;
    int          sent;
    int          got;
    int          cyc;
    sent = 0; got = 0; cyc = 0; hold = 1'b0;
    while (got < N_RAND && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        in_valid = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
        A   = 16'($urandom);
        B   = 16'($urandom);
        Bin = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got %h want no result", {D, Bout, zero, ovf});
        end else begin
          exp_v = q.pop_front();
          if ({D, Bout, zero, ovf} !== exp_v) begin
            n_fail++;
            $display("FAIL rand_result_%0d: got %h want %h", got, {D, Bout, zero, ovf}, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(A, B, Bin));
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (got !== N_RAND) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", got, N_RAND);
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; Bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow_chain();
    test_flags();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_borrow_lookahead_subtractor.md
# pipelined_borrow_lookahead_subtractor

A 16-bit, two-stage pipelined subtractor with two-level borrow lookahead. It computes D = A − B − Bin, together with borrow-out, zero and signed-overflow flags. It is the subtraction counterpart to the team's two-level carry-lookahead adder. The borrow network uses the same 4-bit-block / group generate-propagate structure, split across a register boundary, with a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 16: operand width; fixed at 16, which is 4 blocks of 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- A  input  16  minuend.
- B  input  16  subtrahend.
- Bin  input  1  borrow in.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- D  output  16  difference.
- Bout  output  1  borrow out of bit 15 (1 = unsigned A < B + Bin).
- zero  output  1  D == 0.
- ovf  output  1  signed overflow.
- out_valid  output  1  D and the flags are valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- Bit-level borrow terms:
  - generate g_i = ~A_i & B_i
  - propagate p_i = ~(A_i ^ B_i)
  - recurrence b_{i+1} = g_i | (p_i & b_i), with b_0 = Bin
- Block k (bits 4k..4k+3):
  - G*_k = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - P*_k = p3·p2·p1·p0
- Block borrows, with B0 = Bin:
  - B_{k+1} = G*_k | P*_k·B_k, expanded two-level (not rippled)
  - Bout = B_4
- Stage 1, registered on accept:
  - A ^ B (16 bits), g and p vectors (16 bits each), G*/P* per block (4 each), Bin, A[15], B[15]
  - s1_valid
- Stage 2, registered on advance:
  - compute block borrows, then the in-block bit borrows, then D_i = (A_i ^ B_i) ^ b_i
  - Bout = B_4
  - zero = ~|D
  - ovf = (A15 != B15) & (D15 != A15)
  - out_valid
- Pipeline control is a global stall:
  - advance = out_ready | ~out_valid
  - in_ready = advance
  - when advance = 1: stage 2 loads from stage 1 (s1_valid copies into out_valid), and stage 1 loads inputs (in_valid & in_ready copies into s1_valid)
  - when advance = 0: all pipeline registers hold, and the outputs stay stable
- Data registers load only with a valid token, so D and the flags never change while out_valid = 1 and out_ready = 0.

## Timing
- Reset, async, takes effect immediately:
  - s1_valid = 0, out_valid = 0
  - D = 0x0000, Bout = 0, zero = 0, ovf = 0
  - in_ready = 1 while in reset release, since out_valid = 0
- Latency:
  - operands accepted at edge N appear with out_valid = 1 after edge N+1, i.e. two cycles
  - throughput is 1 result per cycle while out_ready = 1
- Handshake:
  - a transfer occurs on a clock edge where valid & ready are both 1
  - producers may not retract in_valid; the unit does not depend on this
- Stall: with out_ready = 0 and out_valid = 1, in_ready = 0 the same cycle (combinational), and up to 2 results are held in flight.
- Bubbles: out_valid = 0 with in_valid = 0 drains the pipeline at one stage per cycle. An empty stage never blocks acceptance.
- Simultaneous events: an output accept and an input accept in the same cycle are both honoured; the pipeline shifts by one.
- Reset mid-operation: in-flight results are discarded, and no stale out_valid appears after reset deasserts.
- Arithmetic is modulo 2^16; Bin = 1 subtracts one further.

## Test plan
- Reset: assert rst mid-stream with two results in flight -> out_valid = 0, D = 0x0000, all flags 0 immediately, and no result emerges after release.
- Basic: A = 0x1234, B = 0x0234, Bin = 0 -> two cycles later D = 0x1000, Bout = 0, zero = 0, ovf = 0.
- Full borrow chain across all blocks: A = 0x1000, B = 0x0001 -> D = 0x0FFF, Bout = 0. A = 0x0000, B = 0x0001 -> D = 0xFFFF, Bout = 1.
- Flags:
  - A = 0x8000, B = 0x0001 -> D = 0x7FFF, ovf = 1, Bout = 0.
  - A = 0x5555, B = 0x5554, Bin = 1 -> D = 0x0000, zero = 1, Bout = 0.
  - A = 0x7FFF, B = 0xFFFF -> D = 0x8000, ovf = 1, Bout = 1.
- Backpressure: stream 4 operand sets back-to-back while holding out_ready = 0 for cycles 3–5 -> in_ready = 0 during the stall, D held stable, all 4 results delivered in order, none dropped or duplicated.
- Random: 10,000 random A/B/Bin with random in_valid and out_ready -> every output matches A − B − Bin mod 2^16 with the correct Bout, zero and ovf, in order.
